vga_vtiming: RTL and testbench



---
 rtl/vga_vtiming_if.sv | 41 ++++
 rtl/vga_vtiming.sv | 82 ++++++++
 tb/tb_vga_vtiming.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_vtiming_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_vtiming_if
//  Description : Control and timing-output bundle for the vertical timing stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_vtiming_if #(
    parameter int CNT_BIT = 10
);
    logic               i_sclr;
    logic               i_px_clk;
    logic               o_vga_vsync;
    logic               o_de;
    logic [CNT_BIT-1:0] o_x;
    logic [CNT_BIT-1:0] o_y;
    logic               o_line_end;
    logic               o_frame_start;

    modport master (
        output i_sclr,
        output i_px_clk,
        input  o_vga_vsync,
        input  o_de,
        input  o_x,
        input  o_y,
        input  o_line_end,
        input  o_frame_start
    );

    modport slave (
        input  i_sclr,
        input  i_px_clk,
        output o_vga_vsync,
        output o_de,
        output o_x,
        output o_y,
        output o_line_end,
        output o_frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_vtiming.sv
`default_nettype none
// ============================================================================
//  Module      : vga_vtiming
//  Description : Horizontal/vertical counters running in lockstep with the
//                hsync generator; decodes vsync, data-enable and coordinates.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_vtiming #(
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int CNT_BIT   = 10
) (
    input  wire logic    clk,
    input  wire logic    i_rst,
    vga_vtiming_if.slave bus
);

    localparam logic [CNT_BIT-1:0] c_H_LAST      = CNT_BIT'(H_SYNC + H_BACK + H_VISIBLE + H_FRONT - 1);
    localparam logic [CNT_BIT-1:0] c_V_LAST      = CNT_BIT'(V_SYNC + V_BACK + V_VISIBLE + V_FRONT - 1);
    localparam logic [CNT_BIT-1:0] c_H_VIS_START = CNT_BIT'(H_SYNC + H_BACK);
    localparam logic [CNT_BIT-1:0] c_H_VIS_END   = CNT_BIT'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [CNT_BIT-1:0] c_V_VIS_START = CNT_BIT'(V_SYNC + V_BACK);
    localparam logic [CNT_BIT-1:0] c_V_VIS_END   = CNT_BIT'(V_SYNC + V_BACK + V_VISIBLE);
    localparam logic [CNT_BIT-1:0] c_V_SYNC      = CNT_BIT'(V_SYNC);

    logic [CNT_BIT-1:0] r_h_cnt;
    logic [CNT_BIT-1:0] r_v_cnt;
    logic               r_frame_start;

    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_h_vis;
    logic               w_v_vis;
    logic               w_de;

    // ">=" rather than "==" so an out-of-range count recovers to 0 on the next step
    assign w_h_wrap = (r_h_cnt >= c_H_LAST);
    assign w_v_wrap = (r_v_cnt >= c_V_LAST);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_frame_start <= 1'b0;
        end else if (bus.i_sclr) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (bus.i_px_clk) begin
                r_frame_start <= w_h_wrap && w_v_wrap;
                if (w_h_wrap) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end
            end
        end
    end

    assign w_h_vis = (r_h_cnt >= c_H_VIS_START) && (r_h_cnt < c_H_VIS_END);
    assign w_v_vis = (r_v_cnt >= c_V_VIS_START) && (r_v_cnt < c_V_VIS_END);
    assign w_de    = w_h_vis && w_v_vis;

    // Pure decode from the counters keeps vsync aligned with the hsync generator
    assign bus.o_vga_vsync   = (r_v_cnt < c_V_SYNC);
    assign bus.o_de          = w_de;
    assign bus.o_x           = w_de ? (r_h_cnt - c_H_VIS_START) : '0;
    assign bus.o_y           = w_de ? (r_v_cnt - c_V_VIS_START) : '0;
    assign bus.o_line_end    = bus.i_px_clk && (r_h_cnt == c_H_LAST);
    assign bus.o_frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_vtiming.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_vtiming
//  Description : Directed bench: full-size timing (d_*) plus a shrunken
//                13x8 raster (s_*) for frame wrap, gating and clear corners.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_vtiming;

    logic clk;
    logic d_rst;
    logic s_rst;
    int   n_checks;
    int   n_err;

    vga_vtiming_if #(.CNT_BIT(10)) d_if ();
    vga_vtiming_if #(.CNT_BIT(10)) s_if ();

    vga_vtiming u_dut_full (
        .clk   (clk),
        .i_rst (d_rst),
        .bus   (d_if.slave)
    );

    // Small raster: H = 2+3+6+2 = 13 (visible h 5..10), V = 1+2+4+1 = 8 (visible v 3..6)
    vga_vtiming #(
        .H_SYNC(2), .H_BACK(3), .H_VISIBLE(6), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(2), .V_VISIBLE(4), .V_FRONT(1),
        .CNT_BIT(10)
    ) u_dut_small (
        .clk   (clk),
        .i_rst (s_rst),
        .bus   (s_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   steps;
        logic vs;
        logic de;
        int   x;
        int   y;
        logic le;
        logic fs;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic s_steps(input int n);
        for (int i = 0; i < n; i++) begin
            s_if.i_px_clk = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int first_vs_low;
        int first_le;
        int le_cnt;
        int de_cnt;
        int vs_cnt;
        int fs_cnt;
        int fs_at;

        n_checks = 0;
        n_err    = 0;

        // (h,v) targets: (0,0) (12,0) (0,1) (4,3) (5,3) (10,6) (11,6) (12,7) (0,0)' (1,0) (5,2) (5,3)
        vecs[0]  = '{0,  1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
        vecs[1]  = '{12, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0};
        vecs[2]  = '{1,  1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        vecs[3]  = '{30, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        vecs[4]  = '{1,  1'b0, 1'b1, 0, 0, 1'b0, 1'b0};
        vecs[5]  = '{44, 1'b0, 1'b1, 5, 3, 1'b0, 1'b0};
        vecs[6]  = '{1,  1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        vecs[7]  = '{14, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
        vecs[8]  = '{1,  1'b1, 1'b0, 0, 0, 1'b0, 1'b1};
        vecs[9]  = '{1,  1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
        vecs[10] = '{30, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        vecs[11] = '{13, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0};

        d_rst = 1'b1;
        s_rst = 1'b1;
        d_if.i_sclr = 1'b0;  d_if.i_px_clk = 1'b0;
        s_if.i_sclr = 1'b0;  s_if.i_px_clk = 1'b0;

        // Reset state before any clock edge
        #3;
        chk("rst_vsync", 32'(d_if.o_vga_vsync),   1);
        chk("rst_de",    32'(d_if.o_de),          0);
        chk("rst_x",     32'(d_if.o_x),           0);
        chk("rst_y",     32'(d_if.o_y),           0);
        chk("rst_le",    32'(d_if.o_line_end),    0);
        chk("rst_fs",    32'(d_if.o_frame_start), 0);

        @(negedge clk);
        d_rst = 1'b0;
        s_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_vsync", 32'(d_if.o_vga_vsync),   1);
        chk("hold_de",    32'(d_if.o_de),          0);
        chk("hold_fs",    32'(d_if.o_frame_start), 0);
        chk("hold_le",    32'(d_if.o_line_end),    0);

        // Full-size raster, enabled every cycle; sample k sees position k
        first_vs_low = -1;
        first_le     = -1;
        le_cnt       = 0;
        de_cnt       = 0;
        fs_cnt       = 0;
        d_if.i_px_clk = 1'b1;
        for (int k = 0; k < 28800; k++) begin
            @(negedge clk);
            if (!d_if.o_vga_vsync && first_vs_low < 0) first_vs_low = k;
            if (d_if.o_line_end) begin
                le_cnt++;
                if (first_le < 0) first_le = k;
            end
            if (d_if.o_de) de_cnt++;
            if (d_if.o_frame_start) fs_cnt++;
            if (k == 28143) chk("c143_35_de", 32'(d_if.o_de), 0);
            if (k == 28144) begin
                chk("c144_35_de", 32'(d_if.o_de), 1);
                chk("c144_35_x",  32'(d_if.o_x),  0);
                chk("c144_35_y",  32'(d_if.o_y),  0);
            end
            if (k == 28145) chk("c145_35_x", 32'(d_if.o_x), 1);
            if (k == 28783) begin
                chk("c783_35_x", 32'(d_if.o_x), 639);
                chk("c783_35_y", 32'(d_if.o_y), 0);
            end
            if (k == 28784) begin
                chk("c784_35_de", 32'(d_if.o_de), 0);
                chk("c784_35_x",  32'(d_if.o_x),  0);
            end
            @(posedge clk);
            #1;
        end
        d_if.i_px_clk = 1'b0;
        chk("full_vsync_len", 32'(first_vs_low), 1600);
        chk("full_first_le",  32'(first_le),     799);
        chk("full_le_cnt",    32'(le_cnt),       36);
        chk("full_de_cnt",    32'(de_cnt),       640);
        chk("full_fs_cnt",    32'(fs_cnt),       0);

        // Small raster: table of enabled-step counts with expected outputs
        for (int i = 0; i < 12; i++) begin
            s_steps(vecs[i].steps);
            s_if.i_px_clk = 1'b1;
            chk($sformatf("vec%0d_vs", i), 32'(s_if.o_vga_vsync),   32'(vecs[i].vs));
            chk($sformatf("vec%0d_de", i), 32'(s_if.o_de),          32'(vecs[i].de));
            chk($sformatf("vec%0d_x",  i), 32'(s_if.o_x),           32'(vecs[i].x));
            chk($sformatf("vec%0d_y",  i), 32'(s_if.o_y),           32'(vecs[i].y));
            chk($sformatf("vec%0d_le", i), 32'(s_if.o_line_end),    32'(vecs[i].le));
            chk($sformatf("vec%0d_fs", i), 32'(s_if.o_frame_start), 32'(vecs[i].fs));
        end

        // Asynchronous reset mid-frame at (5,3), between clock edges
        s_rst = 1'b1;
        #1;
        chk("midrst_de", 32'(s_if.o_de),        0);
        chk("midrst_vs", 32'(s_if.o_vga_vsync), 1);
        chk("midrst_x",  32'(s_if.o_x),         0);
        s_if.i_px_clk = 1'b0;
        @(negedge clk);
        s_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_vs", 32'(s_if.o_vga_vsync), 1);
        chk("postrst_de", 32'(s_if.o_de),        0);
        s_steps(12);
        chk("postrst_le", 32'(s_if.o_line_end),  1);
        chk("postrst_vs2", 32'(s_if.o_vga_vsync), 1);

        // Clear colliding with the frame wrap at (12,7)
        s_steps(91);
        s_if.i_px_clk = 1'b1;
        chk("coll_pre_le", 32'(s_if.o_line_end),  1);
        chk("coll_pre_vs", 32'(s_if.o_vga_vsync), 0);
        s_if.i_sclr = 1'b1;
        @(posedge clk);
        #1;
        chk("coll_fs", 32'(s_if.o_frame_start), 0);
        chk("coll_vs", 32'(s_if.o_vga_vsync),   1);
        chk("coll_le", 32'(s_if.o_line_end),    0);
        s_if.i_sclr = 1'b0;
        s_steps(12);
        chk("coll_post_le", 32'(s_if.o_line_end),    1);
        chk("coll_post_vs", 32'(s_if.o_vga_vsync),   1);
        chk("coll_post_fs", 32'(s_if.o_frame_start), 0);

        // Enable 1-of-4: one enabled edge after samples k = 0,4,8,...
        s_if.i_px_clk = 1'b0;
        s_rst = 1'b1;
        #1;
        @(negedge clk);
        s_rst = 1'b0;
        @(posedge clk);
        #1;
        le_cnt = 0; de_cnt = 0; vs_cnt = 0; fs_cnt = 0; fs_at = -1;
        for (int k = 0; k < 420; k++) begin
            s_if.i_px_clk = (k % 4 == 0);
            @(negedge clk);
            if (k <= 412) begin
                if (s_if.o_line_end)  le_cnt++;
                if (s_if.o_de)        de_cnt++;
                if (s_if.o_vga_vsync) vs_cnt++;
            end
            if (s_if.o_frame_start) begin
                fs_cnt++;
                if (fs_at < 0) fs_at = k;
            end
            @(posedge clk);
            #1;
        end
        s_if.i_px_clk = 1'b0;
        chk("gate_le_cnt", 32'(le_cnt), 8);
        chk("gate_de_cnt", 32'(de_cnt), 96);
        chk("gate_vs_cnt", 32'(vs_cnt), 49);
        chk("gate_fs_cnt", 32'(fs_cnt), 1);
        chk("gate_fs_at",  32'(fs_at),  413);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
